// File: rtl/emulador_hcsr04.sv
// emulador_hcsr04: responder end of an HC-SR04 trigger/echo link.
// Validates the trigger width, waits a fixed burst delay, then drives a
// registered echo pulse whose width is distance * CICLOS_POR_CM cycles.
// Echo and ocupado are registered one edge behind the state register, so
// echo rises one edge after ECO is entered and ocupado falls one edge
// after the state returns to OCIOSO.
module emulador_hcsr04 #(
  parameter int CICLOS_TRIG_MIN = 500,
  parameter int CICLOS_ATRASO   = 10000,
  parameter int CICLOS_POR_CM   = 2941,
  parameter int DIST_MAX        = 400,
  parameter int CICLOS_HOLDOFF  = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  input  logic       sem_eco,
  output logic       echo,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    MEDE_TRIG = 3'd1,
    ATRASO    = 3'd2,
    ECO       = 3'd3,
    HOLDOFF   = 3'd4
  } estado_t;

  // Terminal counts; timers count from 0 up to N-1 so each phase lasts N edges.
  localparam logic [15:0] TRIG_MIN_W  = 16'(CICLOS_TRIG_MIN);
  localparam logic [15:0] ATRASO_FIM  = 16'(CICLOS_ATRASO - 1);
  localparam logic [15:0] HOLDOFF_FIM = 16'(CICLOS_HOLDOFF - 1);
  localparam logic [11:0] POR_CM_FIM  = 12'(CICLOS_POR_CM - 1);
  localparam logic [8:0]  DIST_MAX_W  = 9'(DIST_MAX);

  estado_t     estado_q, estado_d;
  logic [15:0] trig_cnt_q, trig_cnt_d;  // trigger high-time, saturating
  logic [15:0] tmr_q, tmr_d;            // shared ATRASO / HOLDOFF timer
  logic [11:0] sub_q, sub_d;            // cycles within the current cm
  logic [8:0]  cm_q, cm_d;              // completed cm of echo
  logic [8:0]  dist_q, dist_d;          // distance latched at trigger fall
  logic        sem_eco_q, sem_eco_d;    // echo suppression latched at trigger fall
  logic        trig_prev_q, trig_prev_d;
  logic        echo_q, echo_d;
  logic        ocupado_q, ocupado_d;

  // State register and all counters; synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      trig_cnt_q  <= '0;
      tmr_q       <= '0;
      sub_q       <= '0;
      cm_q        <= '0;
      dist_q      <= '0;
      sem_eco_q   <= 1'b0;
      trig_prev_q <= 1'b0;
      echo_q      <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      trig_cnt_q  <= trig_cnt_d;
      tmr_q       <= tmr_d;
      sub_q       <= sub_d;
      cm_q        <= cm_d;
      dist_q      <= dist_d;
      sem_eco_q   <= sem_eco_d;
      trig_prev_q <= trig_prev_d;
      echo_q      <= echo_d;
      ocupado_q   <= ocupado_d;
    end
  end

  // Next-state, counter updates and registered-output inputs.
  always_comb begin
    estado_d    = estado_q;
    trig_cnt_d  = trig_cnt_q;
    tmr_d       = tmr_q;
    sub_d       = sub_q;
    cm_d        = cm_q;
    dist_d      = dist_q;
    sem_eco_d   = sem_eco_q;
    trig_prev_d = trigger;

    case (estado_q)
      OCIOSO: begin
        // Rising edge only: a trigger held high through HOLDOFF exit must
        // drop and rise again before it starts a new measurement.
        if (trigger && !trig_prev_q) begin
          estado_d   = MEDE_TRIG;
          trig_cnt_d = 16'd1;
        end
      end

      MEDE_TRIG: begin
        if (trigger) begin
          if (trig_cnt_q != 16'hFFFF) trig_cnt_d = trig_cnt_q + 16'd1;
        end else begin
          trig_cnt_d = '0;
          if (trig_cnt_q >= TRIG_MIN_W) begin
            dist_d    = distancia;
            sem_eco_d = sem_eco;
            tmr_d     = '0;
            estado_d  = ATRASO;
          end else begin
            estado_d = OCIOSO;
          end
        end
      end

      ATRASO: begin
        if (tmr_q == ATRASO_FIM) begin
          tmr_d = '0;
          if (sem_eco_q || (dist_q == 9'd0) || (dist_q > DIST_MAX_W)) begin
            estado_d = HOLDOFF;
          end else begin
            sub_d    = '0;
            cm_d     = '0;
            estado_d = ECO;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      ECO: begin
        if (sub_q == POR_CM_FIM) begin
          sub_d = '0;
          if (cm_q == dist_q - 9'd1) begin
            cm_d     = '0;
            tmr_d    = '0;
            estado_d = HOLDOFF;
          end else begin
            cm_d = cm_q + 9'd1;
          end
        end else begin
          sub_d = sub_q + 12'd1;
        end
      end

      HOLDOFF: begin
        if (tmr_q == HOLDOFF_FIM) begin
          tmr_d    = '0;
          estado_d = OCIOSO;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      default: begin
        // Illegal encoding: drop back to idle with clean counters.
        estado_d   = OCIOSO;
        trig_cnt_d = '0;
        tmr_d      = '0;
        sub_d      = '0;
        cm_d       = '0;
      end
    endcase

    echo_d    = (estado_q == ECO);
    // Rises on MEDE_TRIG entry, falls one edge after OCIOSO is reached,
    // keeping the echo-fall to ocupado-fall gap equal to the holdoff.
    ocupado_d = (estado_q != OCIOSO) || (estado_d != OCIOSO);
  end

  // Debug state code; anything outside the defined states reads as 7.
  always_comb begin
    case (estado_q)
      OCIOSO, MEDE_TRIG, ATRASO, ECO, HOLDOFF: db_estado = estado_q;
      default:                                 db_estado = 3'd7;
    endcase
  end

  assign echo    = echo_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Directed bench for emulador_hcsr04 with shortened timing parameters.
module tb_emulador_hcsr04;

  localparam int TMIN = 5;
  localparam int ATR  = 20;
  localparam int PCM  = 7;
  localparam int DMAX = 10;
  localparam int HOLD = 30;
  localparam int RISE = ATR + 1;         // echo rise, edges after t0
  localparam int NOECHO_OFF = ATR + 1 + HOLD;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [8:0] distancia;
  logic       sem_eco;
  logic       echo;
  logic       ocupado;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  emulador_hcsr04 #(
    .CICLOS_TRIG_MIN(TMIN),
    .CICLOS_ATRASO  (ATR),
    .CICLOS_POR_CM  (PCM),
    .DIST_MAX       (DMAX),
    .CICLOS_HOLDOFF (HOLD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .distancia(distancia),
    .sem_eco  (sem_eco),
    .echo     (echo),
    .ocupado  (ocupado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse trigger for tlen samples, then watch until ocupado drops.
  // Times are edges after t0 (-1 if never seen). Optional trigger window
  // [tr_on, tr_off) and an input change at chg_at (also sets sem_eco).
  task automatic measure(input int tlen, input logic [8:0] d, input logic se,
                         input int tr_on, input int tr_off,
                         input int chg_at, input logic [8:0] chg_d,
                         output int rise, output int fall, output int ofall,
                         output int ecnt);
    int t0;
    logic pe;
    distancia = d;
    sem_eco   = se;
    trigger   = 1'b1;
    repeat (tlen) tick();
    trigger = 1'b0;
    tick();
    t0 = cyc;
    rise = -1; fall = -1; ofall = -1; ecnt = 0; pe = 1'b0;
    for (int k = 1; k < 4000 && ofall < 0; k++) begin
      trigger = (k >= tr_on) && (k < tr_off);
      if (k == chg_at) begin
        distancia = chg_d;
        sem_eco   = 1'b1;
      end
      tick();
      if (echo) ecnt++;
      if (echo && !pe) rise = cyc - t0;
      if (!echo && pe) fall = cyc - t0;
      if (!ocupado) ofall = cyc - t0;
      pe = echo;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = 1'b0; distancia = '0; sem_eco = 1'b0;
    repeat (3) tick();
    tests++; if (echo !== 1'b0) begin fails++; $display("FAIL reset_echo got %b want 0", echo); end
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    tests++; if (db_estado !== 3'd0) begin fails++; $display("FAIL reset_estado got %0d want 0", db_estado); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_states();
    distancia = 9'd1; sem_eco = 1'b0;
    trigger = 1'b1;
    tick();
    tests++; if (db_estado !== 3'd1) begin fails++; $display("FAIL st_mede got %0d want 1", db_estado); end
    tests++; if (ocupado !== 1'b1) begin fails++; $display("FAIL st_ocupado got %b want 1", ocupado); end
    repeat (TMIN - 1) tick();
    trigger = 1'b0;
    tick();  // t0
    tests++; if (db_estado !== 3'd2) begin fails++; $display("FAIL st_atraso got %0d want 2", db_estado); end
    repeat (ATR) tick();
    tests++; if (db_estado !== 3'd3) begin fails++; $display("FAIL st_eco got %0d want 3", db_estado); end
    tests++; if (echo !== 1'b0) begin fails++; $display("FAIL st_echo_pre got %b want 0", echo); end
    tick();
    tests++; if (echo !== 1'b1) begin fails++; $display("FAIL st_echo_rise got %b want 1", echo); end
    repeat (PCM - 1) tick();
    tests++; if (db_estado !== 3'd4 || echo !== 1'b1) begin fails++; $display("FAIL st_holdoff got %0d/%b want 4/1", db_estado, echo); end
    tick();
    tests++; if (echo !== 1'b0) begin fails++; $display("FAIL st_echo_fall got %b want 0", echo); end
    repeat (HOLD + 2) tick();
    tests++; if (ocupado !== 1'b0 || db_estado !== 3'd0) begin fails++; $display("FAIL st_idle got %b/%0d want 0/0", ocupado, db_estado); end
  endtask

  task automatic test_echo_width();
    int r, f, o, e;
    measure(TMIN, 9'd3, 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (r !== RISE) begin fails++; $display("FAIL d3_rise got %0d want %0d", r, RISE); end
    tests++; if (f - r !== 3 * PCM) begin fails++; $display("FAIL d3_width got %0d want %0d", f - r, 3 * PCM); end
    tests++; if (e !== 3 * PCM) begin fails++; $display("FAIL d3_count got %0d want %0d", e, 3 * PCM); end
    tests++; if (o - f !== HOLD) begin fails++; $display("FAIL d3_holdoff got %0d want %0d", o - f, HOLD); end
    measure(TMIN, 9'(DMAX), 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== DMAX * PCM || f - r !== DMAX * PCM) begin fails++; $display("FAIL dmax_width got %0d/%0d want %0d", e, f - r, DMAX * PCM); end
  endtask

  task automatic test_latch_change();
    int r, f, o, e;
    measure(TMIN, 9'd3, 1'b0, 0, 0, RISE + 4, 9'd9, r, f, o, e);
    tests++; if (e !== 3 * PCM) begin fails++; $display("FAIL chg_width got %0d want %0d", e, 3 * PCM); end
    tests++; if (o - f !== HOLD) begin fails++; $display("FAIL chg_holdoff got %0d want %0d", o - f, HOLD); end
    sem_eco = 1'b0;
  endtask

  task automatic test_trig_min();
    int r, f, o, e;
    int cnt;
    distancia = 9'd3; sem_eco = 1'b0;
    trigger = 1'b1;
    repeat (TMIN - 1) tick();
    trigger = 1'b0;
    tick();
    tests++; if (db_estado !== 3'd0) begin fails++; $display("FAIL short_estado got %0d want 0", db_estado); end
    cnt = 0;
    for (int k = 0; k < ATR + 3 * PCM + 10; k++) begin
      tick();
      if (echo) cnt++;
    end
    tests++; if (cnt !== 0) begin fails++; $display("FAIL short_echo got %0d want 0", cnt); end
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL short_ocupado got %b want 0", ocupado); end
    measure(TMIN, 9'd2, 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 2 * PCM || r !== RISE) begin fails++; $display("FAIL min_trig got %0d@%0d want %0d@%0d", e, r, 2 * PCM, RISE); end
  endtask

  task automatic test_no_echo();
    int r, f, o, e;
    measure(TMIN, 9'd3, 1'b1, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 0) begin fails++; $display("FAIL semeco_echo got %0d want 0", e); end
    tests++; if (o !== NOECHO_OFF) begin fails++; $display("FAIL semeco_ocupado got %0d want %0d", o, NOECHO_OFF); end
    measure(TMIN, 9'(DMAX + 1), 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 0) begin fails++; $display("FAIL dover_echo got %0d want 0", e); end
    tests++; if (o !== NOECHO_OFF) begin fails++; $display("FAIL dover_ocupado got %0d want %0d", o, NOECHO_OFF); end
    measure(TMIN, 9'd0, 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 0) begin fails++; $display("FAIL dzero_echo got %0d want 0", e); end
    tests++; if (o !== NOECHO_OFF) begin fails++; $display("FAIL dzero_ocupado got %0d want %0d", o, NOECHO_OFF); end
  endtask

  task automatic test_retrigger();
    int r, f, o, e;
    // Extra pulse while echo is high.
    measure(TMIN, 9'd3, 1'b0, RISE + 4, RISE + 12, 0, 9'd0, r, f, o, e);
    tests++; if (r !== RISE || e !== 3 * PCM) begin fails++; $display("FAIL retrig_eco got %0d@%0d want %0d@%0d", e, r, 3 * PCM, RISE); end
    tests++; if (o - f !== HOLD) begin fails++; $display("FAIL retrig_eco_hold got %0d want %0d", o - f, HOLD); end
    // Extra pulse during holdoff.
    measure(TMIN, 9'd3, 1'b0, RISE + 3 * PCM + 8, RISE + 3 * PCM + 16, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 3 * PCM || o - f !== HOLD) begin fails++; $display("FAIL retrig_hold got %0d/%0d want %0d/%0d", e, o - f, 3 * PCM, HOLD); end
    // Trigger rises in holdoff and stays high past its end.
    measure(TMIN, 9'd3, 1'b0, RISE + 3 * PCM + 18, 100000, 0, 9'd0, r, f, o, e);
    tests++; if (trigger !== 1'b1 || o - f !== HOLD) begin fails++; $display("FAIL held_setup got %b/%0d want 1/%0d", trigger, o - f, HOLD); end
    repeat (10) tick();
    tests++; if (db_estado !== 3'd0 || ocupado !== 1'b0) begin fails++; $display("FAIL held_ignored got %0d/%b want 0/0", db_estado, ocupado); end
    trigger = 1'b0;
    tick();
    measure(TMIN, 9'd1, 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== PCM || r !== RISE) begin fails++; $display("FAIL held_retoggle got %0d@%0d want %0d@%0d", e, r, PCM, RISE); end
  endtask

  task automatic test_reset_mid();
    int r, f, o, e;
    distancia = 9'(DMAX); sem_eco = 1'b0;
    trigger = 1'b1;
    repeat (TMIN) tick();
    trigger = 1'b0;
    tick();
    repeat (RISE + 30) tick();
    tests++; if (echo !== 1'b1 || db_estado !== 3'd3) begin fails++; $display("FAIL mid_pre got %b/%0d want 1/3", echo, db_estado); end
    reset = 1'b1;
    tick();
    tests++; if (echo !== 1'b0 || db_estado !== 3'd0 || ocupado !== 1'b0) begin fails++; $display("FAIL mid_reset got %b/%0d/%b want 0/0/0", echo, db_estado, ocupado); end
    reset = 1'b0;
    tick();
    measure(TMIN, 9'd2, 1'b0, 0, 0, 0, 9'd0, r, f, o, e);
    tests++; if (e !== 2 * PCM || r !== RISE || o - f !== HOLD) begin fails++; $display("FAIL mid_after got %0d@%0d/%0d want %0d@%0d/%0d", e, r, o - f, 2 * PCM, RISE, HOLD); end
  endtask

  initial begin
    test_reset();
    test_states();
    test_echo_width();
    test_latch_change();
    test_trig_min();
    test_no_echo();
    test_retrigger();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emulador_hcsr04.md
# emulador_hcsr04

Synthesizable HC-SR04 ultrasonic sensor model: the responder end of the trigger/echo interface driven by the neurosync sensor interface. The block watches `trigger`, validates the pulse width, waits a fixed burst delay and then raises `echo` for a width proportional to a programmed distance. It can also suppress the echo to exercise the controller's timeout path. It is used on the FPGA loopback build and in benches in place of hand-timed `echo` stimulus.

## Interface
- `CICLOS_TRIG_MIN`, 500: minimum trigger high time in clock cycles (10 µs at 50 MHz).
- `CICLOS_ATRASO`, 10000: cycles from validated trigger fall to echo rise (200 µs burst).
- `CICLOS_POR_CM`, 2941: echo cycles per cm (58.82 µs/cm).
- `DIST_MAX`, 400: largest distance in cm that produces an echo.
- `CICLOS_HOLDOFF`, 50000: dead time after a measurement completes (1 ms).
- `clock` in 1: system clock, 50 MHz; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `trigger` in 1: trigger from the controller. Sampled directly; it is synchronous to `clock`.
- `distancia` in 9: target distance in cm. Latched on the validated trigger fall.
- `sem_eco` in 1: when high at latch time, no echo is produced (timeout case).
- `echo` out 1: registered echo pulse.
- `ocupado` out 1: high in every state except OCIOSO.
- `db_estado` out 3: state code.

## Operation
- State codes: OCIOSO=0, MEDE_TRIG=1, ATRASO=2, ECO=3, HOLDOFF=4, and 7 for illegal states. Any illegal state returns to OCIOSO on the next edge.
- OCIOSO: `trigger`=1 moves to MEDE_TRIG and loads the trigger counter with 1.
- MEDE_TRIG, while `trigger`=1: the counter increments and saturates at 16 bits.
- MEDE_TRIG, on `trigger`=0:
  - If the count is ≥ `CICLOS_TRIG_MIN`, latch `distancia` and `sem_eco`, then go to ATRASO.
  - Otherwise return to OCIOSO. The pulse is discarded and no other side effect occurs.
- ATRASO: count `CICLOS_ATRASO` cycles. At the end:
  - Go to HOLDOFF if any of these hold on the latched values: `sem_eco`=1, distance=0, or distance > `DIST_MAX`.
  - Otherwise go to ECO.
- ECO: `echo`=1. A sub-counter counts `CICLOS_POR_CM` cycles per cm and a cm counter counts up to the latched distance. When the last cm completes, go to HOLDOFF.
- HOLDOFF: count `CICLOS_HOLDOFF` cycles, then go to OCIOSO.
- Retriggering:
  - `trigger` activity in ATRASO, ECO or HOLDOFF is ignored.
  - A trigger still high on HOLDOFF exit is not accepted until it has gone low and risen again. Track this with the previous trigger sample.
- Widths:
  - Sub-counter is 12 bits; cm counter is 9 bits.
  - Echo width is exactly latched distance × `CICLOS_POR_CM` cycles, with no rounding.
- Changes to `distancia` or `sem_eco` after the latch have no effect on the measurement in flight.

## Timing
- Reset values:
  - State OCIOSO.
  - `echo`=0, `ocupado`=0, `db_estado`=0.
  - All counters 0; latched distance 0.
- Reset asserted mid-operation, including during ECO: `echo` is 0 after that edge and the measurement is abandoned.
- Trigger fall:
  - Edge t0 is the first edge that samples `trigger`=0 after a valid high run.
  - `ocupado` stays 1 from entry to MEDE_TRIG through the end of HOLDOFF.
- Echo timing:
  - `echo` rises at edge t0 + `CICLOS_ATRASO` + 1.
  - `echo` stays high for exactly latched distance × `CICLOS_POR_CM` cycles.
  - `echo` is a registered output, so there are no glitches.
- After the echo:
  - `ocupado` falls `CICLOS_HOLDOFF` cycles after `echo` falls.
  - In the no-echo case, `ocupado` falls `CICLOS_HOLDOFF` cycles after ATRASO ends.
- A trigger exactly `CICLOS_TRIG_MIN` cycles long is accepted. One cycle shorter is rejected.

## Test plan
- `distancia`=100, 10 µs trigger → `echo` high for 294100 cycles (5882 µs), rising 10001 cycles after t0; `ocupado` drops 50000 cycles after `echo` falls.
- `distancia`=75 → echo 220575 cycles (4411.5 µs). Then change `distancia` to 200 mid-echo → width is unchanged.
- Trigger of 499 cycles → no echo, state back to 0 immediately. Trigger of 500 cycles → echo produced.
- `sem_eco`=1, and separately `distancia`=401 and `distancia`=0 → `echo` stays 0; `ocupado` stays high for `CICLOS_ATRASO` + `CICLOS_HOLDOFF` cycles.
- Second trigger during ECO and during HOLDOFF → ignored; echo count and width are unchanged. A trigger held high across HOLDOFF exit → not accepted until it toggles.
- Reset asserted 1000 cycles into ECO → `echo`=0, `db_estado`=0 and `ocupado`=0 after the next edge. A fresh valid trigger then measures normally.
